spi_word_assembler: RTL and testbench

//  Receive-side stage directly downstream of spi_slave_driver in the slave SPI PU.

---
 rtl/spi_pkg.sv | 31 +++
 rtl/spi_word_assembler_if.sv | 45 ++++
 rtl/spi_word_assembler.sv | 152 +++++++++++++++
 tb/tb_spi_word_assembler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI processing unit datapath stages
// (spi_word_assembler on the receive side, nitta_to_spi_splitter on the
// transmit side).
//   state_t        : two-state frame FSM encoding (IDLE, ACTIVE)
//   clog2          : ceiling log2 usable in parameter/localparam context
//   bytes_per_word : number of SPI bytes that make up one processor word
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Returns the number of bits needed to encode values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int bytes_per_word(input int data_width, input int spi_width);
        return data_width / spi_width;
    endfunction

endpackage

// File: rtl/spi_word_assembler_if.sv
// ---------------------------------------------------------------------------
// spi_word_assembler_if
// Bundles the byte stream from the SPI slave driver, the receive buffer
// write port and the frame status outputs of spi_word_assembler.
//   cs, byte_valid, spi_data : byte stream and chip select (driver side)
//   buf_full                 : receive buffer back-pressure
//   word_wr, word_data       : 1-cycle write strobe and word to the buffer
//   frame_words              : words written in current/last frame
//   frame_done               : 1-cycle end-of-frame pulse
//   overflow, frame_err      : sticky status flags
// Modports:
//   master : the environment (driver + buffer) side
//   slave  : the assembler itself
// ---------------------------------------------------------------------------
interface spi_word_assembler_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int BUF_SIZE       = 6
) ();
    import spi_pkg::*;

    localparam int FW_WIDTH = clog2(BUF_SIZE + 1);

    logic                      cs;
    logic                      byte_valid;
    logic [SPI_DATA_WIDTH-1:0] spi_data;
    logic                      buf_full;
    logic                      word_wr;
    logic [DATA_WIDTH-1:0]     word_data;
    logic [FW_WIDTH-1:0]       frame_words;
    logic                      frame_done;
    logic                      overflow;
    logic                      frame_err;

    modport master (
        output cs, byte_valid, spi_data, buf_full,
        input  word_wr, word_data, frame_words, frame_done, overflow, frame_err
    );

    modport slave (
        input  cs, byte_valid, spi_data, buf_full,
        output word_wr, word_data, frame_words, frame_done, overflow, frame_err
    );

endinterface

// File: rtl/spi_word_assembler.sv
// ---------------------------------------------------------------------------
// spi_word_assembler
// Packs SPI bytes MSB-first into DATA_WIDTH words and writes each complete
// word into the receive buffer with a 1-cycle strobe. Frames are delimited
// by cs (0 = active). Reports per-frame word count, overflow and framing
// errors.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-low
//   bus  : spi_word_assembler_if.slave (see interface for signal list)
// Configuration macro:
//   SPI_ASSEMBLER_FLUSH_EN : when defined, a partial word at end of frame is
//                            left-aligned, zero-padded and written (same
//                            acceptance rules). Undefined: it is discarded.
//                            frame_err is set in both cases.
// All outputs are registered; word_wr follows the completing byte strobe by
// one clock.
// ---------------------------------------------------------------------------
module spi_word_assembler
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int BUF_SIZE       = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_word_assembler_if.slave  bus
);

    localparam int BPW       = bytes_per_word(DATA_WIDTH, SPI_DATA_WIDTH);
    localparam int CNT_WIDTH = (BPW > 1) ? clog2(BPW) : 1;
    localparam int FW_WIDTH  = clog2(BUF_SIZE + 1);

    localparam logic [CNT_WIDTH-1:0] LAST_BYTE = CNT_WIDTH'(BPW - 1);
    localparam logic [FW_WIDTH-1:0]  FW_MAX    = FW_WIDTH'(BUF_SIZE);

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    word_wr_q, word_wr_d;
    logic [DATA_WIDTH-1:0]   word_data_q, word_data_d;
    logic [FW_WIDTH-1:0]     frame_words_q, frame_words_d;
    logic                    frame_done_q, frame_done_d;
    logic                    overflow_q, overflow_d;
    logic                    frame_err_q, frame_err_d;

    logic                    write_req;
    logic [DATA_WIDTH-1:0]   write_word;

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        shreg_d       = shreg_q;
        word_wr_d     = 1'b0;
        word_data_d   = word_data_q;
        frame_words_d = frame_words_q;
        frame_done_d  = 1'b0;
        overflow_d    = overflow_q;
        frame_err_d   = frame_err_q;
        write_req     = 1'b0;
        write_word    = '0;

        case (state_q)
            IDLE: begin
                // Frame start wipes all per-frame state including sticky flags.
                if (!bus.cs) begin
                    state_d       = ACTIVE;
                    byte_cnt_d    = '0;
                    shreg_d       = '0;
                    frame_words_d = '0;
                    overflow_d    = 1'b0;
                    frame_err_d   = 1'b0;
                end
            end

            ACTIVE: begin
                if (bus.byte_valid) begin
                    shreg_d = {shreg_q[DATA_WIDTH-SPI_DATA_WIDTH-1:0], bus.spi_data};
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        write_req  = 1'b1;
                        write_word = shreg_d;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end

                // End of frame is judged on the count after this cycle's byte,
                // so a completing byte arriving with cs rising is not an error.
                if (bus.cs) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                    if (byte_cnt_d != '0) begin
                        frame_err_d = 1'b1;
`ifdef SPI_ASSEMBLER_FLUSH_EN
                        write_req  = 1'b1;
                        write_word = shreg_d << (SPI_DATA_WIDTH * (BPW - int'(byte_cnt_d)));
`endif
                        byte_cnt_d = '0;
                    end
                end

                // A word that cannot be stored is dropped; word_data keeps
                // the last word that was actually written.
                if (write_req) begin
                    if (!bus.buf_full && (frame_words_q < FW_MAX)) begin
                        word_wr_d     = 1'b1;
                        word_data_d   = write_word;
                        frame_words_d = frame_words_q + 1'b1;
                    end else begin
                        overflow_d    = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            byte_cnt_q    <= '0;
            shreg_q       <= '0;
            word_wr_q     <= 1'b0;
            word_data_q   <= '0;
            frame_words_q <= '0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            shreg_q       <= shreg_d;
            word_wr_q     <= word_wr_d;
            word_data_q   <= word_data_d;
            frame_words_q <= frame_words_d;
            frame_done_q  <= frame_done_d;
            overflow_q    <= overflow_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign bus.word_wr     = word_wr_q;
    assign bus.word_data   = word_data_q;
    assign bus.frame_words = frame_words_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.overflow    = overflow_q;
    assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_word_assembler.sv
// ---------------------------------------------------------------------------
// tb_spi_word_assembler
// Directed testbench for spi_word_assembler (DATA_WIDTH=32, SPI_DATA_WIDTH=8,
// BUF_SIZE=6). Inputs change on the falling clock edge; outputs are sampled
// on the following falling edge, i.e. after the rising edge that consumed
// the inputs. Honours SPI_ASSEMBLER_FLUSH_EN for the partial-word case.
// ---------------------------------------------------------------------------
module tb_spi_word_assembler;

    logic clk;
    logic rst;

    int checks;
    int errors;

    spi_word_assembler_if #(
        .DATA_WIDTH    (32),
        .SPI_DATA_WIDTH(8),
        .BUF_SIZE      (6)
    ) bus ();

    spi_word_assembler #(
        .DATA_WIDTH    (32),
        .SPI_DATA_WIDTH(8),
        .BUF_SIZE      (6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one clock cycle worth of inputs and returns after the rising
    // edge that consumed them, at the next falling edge.
    task automatic apply_stimulus(input logic cs_i, input logic bv_i,
                                  input logic [7:0] data_i, input logic full_i);
        bus.cs         = cs_i;
        bus.byte_valid = bv_i;
        bus.spi_data   = data_i;
        bus.buf_full   = full_i;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        apply_stimulus(1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [31:0] word;
        checks = 0;
        errors = 0;

        rst            = 1'b0;
        bus.cs         = 1'b1;
        bus.byte_valid = 1'b0;
        bus.spi_data   = '0;
        bus.buf_full   = 1'b0;
        repeat (3) @(negedge clk);

        check_output("reset_word_wr",     32'(bus.word_wr),     32'd0);
        check_output("reset_word_data",   bus.word_data,        32'd0);
        check_output("reset_frame_words", 32'(bus.frame_words), 32'd0);
        check_output("reset_flags",
                     {29'd0, bus.frame_done, bus.overflow, bus.frame_err}, 32'd0);
        rst = 1'b1;

        // 1: one full word DEADBEEF
        $display("[TB] step 1: single word");
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        check_output("t1_no_early_wr", 32'(bus.word_wr), 32'd0);
        send_byte(8'hEF);
        check_output("t1_word_wr",     32'(bus.word_wr),     32'd1);
        check_output("t1_word_data",   bus.word_data,        32'hDEADBEEF);
        check_output("t1_frame_words", 32'(bus.frame_words), 32'd1);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check_output("t1_wr_one_cycle", 32'(bus.word_wr),  32'd0);
        check_output("t1_data_hold",    bus.word_data,     32'hDEADBEEF);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        check_output("t1_frame_done", 32'(bus.frame_done), 32'd1);
        check_output("t1_frame_err",  32'(bus.frame_err),  32'd0);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        check_output("t1_done_pulse", 32'(bus.frame_done),  32'd0);
        check_output("t1_words_hold", 32'(bus.frame_words), 32'd1);

        // 2: fill the buffer allowance, seventh word overflows
        $display("[TB] step 2: frame word limit");
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check_output("t2_words_cleared", 32'(bus.frame_words), 32'd0);
        for (int i = 0; i < 6; i++) begin
            word = 32'h01010101 * (i + 1);
            for (int j = 0; j < 4; j++) send_byte(word[31-8*j -: 8]);
            check_output($sformatf("t2_wr_%0d", i),   32'(bus.word_wr), 32'd1);
            check_output($sformatf("t2_data_%0d", i), bus.word_data,    word);
        end
        for (int j = 0; j < 4; j++) send_byte(8'h07);
        check_output("t2_drop_wr",     32'(bus.word_wr),     32'd0);
        check_output("t2_overflow",    32'(bus.overflow),    32'd1);
        check_output("t2_frame_words", 32'(bus.frame_words), 32'd6);
        check_output("t2_data_kept",   bus.word_data,        32'h06060606);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        check_output("t2_ovf_sticky",  32'(bus.overflow),  32'd1);
        check_output("t2_frame_err",   32'(bus.frame_err), 32'd0);

        // 3: buffer full when the word completes
        $display("[TB] step 3: buffer full");
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check_output("t3_ovf_cleared", 32'(bus.overflow), 32'd0);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        apply_stimulus(1'b0, 1'b1, 8'h78, 1'b1);
        check_output("t3_no_wr",       32'(bus.word_wr),     32'd0);
        check_output("t3_overflow",    32'(bus.overflow),    32'd1);
        check_output("t3_frame_words", 32'(bus.frame_words), 32'd0);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check_output("t3_new_frame_ovf", 32'(bus.overflow), 32'd0);

        // 4: partial word at end of frame
        $display("[TB] step 4: partial word");
        send_byte(8'h11);
        send_byte(8'h22);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        check_output("t4_frame_done", 32'(bus.frame_done), 32'd1);
        check_output("t4_frame_err",  32'(bus.frame_err),  32'd1);
`ifdef SPI_ASSEMBLER_FLUSH_EN
        check_output("t4_flush_wr",    32'(bus.word_wr),     32'd1);
        check_output("t4_flush_data",  bus.word_data,        32'h11220000);
        check_output("t4_frame_words", 32'(bus.frame_words), 32'd1);
`else
        check_output("t4_no_wr",       32'(bus.word_wr),     32'd0);
        check_output("t4_data_kept",   bus.word_data,        32'h06060606);
        check_output("t4_frame_words", 32'(bus.frame_words), 32'd0);
`endif
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        check_output("t4_err_sticky", 32'(bus.frame_err), 32'd1);

        // 5: last byte coincides with cs rising
        $display("[TB] step 5: last byte at frame end");
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check_output("t5_err_cleared", 32'(bus.frame_err), 32'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        apply_stimulus(1'b1, 1'b1, 8'h04, 1'b0);
        check_output("t5_word_wr",     32'(bus.word_wr),     32'd1);
        check_output("t5_word_data",   bus.word_data,        32'h01020304);
        check_output("t5_frame_done",  32'(bus.frame_done),  32'd1);
        check_output("t5_frame_err",   32'(bus.frame_err),   32'd0);
        check_output("t5_frame_words", 32'(bus.frame_words), 32'd1);

        // 6: asynchronous reset in the middle of a word
        $display("[TB] step 6: async reset");
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        check_output("t6_pre_data", bus.word_data, 32'h55667788);
        send_byte(8'h99);
        send_byte(8'h98);
        #2;
        bus.byte_valid = 1'b0;
        bus.cs         = 1'b1;
        rst            = 1'b0;
        #1;
        check_output("t6_rst_data",  bus.word_data,        32'd0);
        check_output("t6_rst_words", 32'(bus.frame_words), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        check_output("t6_word_wr",     32'(bus.word_wr),     32'd1);
        check_output("t6_word_data",   bus.word_data,        32'hAABBCCDD);
        check_output("t6_frame_words", 32'(bus.frame_words), 32'd1);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
